// File: rtl/qracc_pkg.sv
// qracc_pkg
// Shared types and constants for the QR-ACC compute-in-memory sequencer.
//   seq_state_t          : sequencer FSM states
//   QRACC_DEFAULT_SETTLE : suggested analog settle time in cycles
//   after_write_state()  : where a job goes once its weight rows are loaded
package qracc_pkg;

    localparam int QRACC_DEFAULT_SETTLE = 5;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETTLE,
        MAC_LOAD,
        MAC_EVAL,
        MAC_OUT,
        DONE
    } seq_state_t;

    // A zero settle count skips SETTLE entirely, and a zero batch count
    // skips the MAC phase, so the exit from the write phase (or from IDLE
    // when no rows are written) depends on both settings.
    function automatic seq_state_t after_write_state(input logic [3:0]  settle,
                                                     input logic [15:0] n_batches);
        if (settle != 4'd0) begin
            return SETTLE;
        end
        if (n_batches != 16'd0) begin
            return MAC_LOAD;
        end
        return DONE;
    endfunction

endpackage

// File: rtl/qracc_sequencer.sv
// qracc_sequencer
// Job sequencer for a charge-domain CIM macro: loads weight rows into the
// SRAM, waits for the array to settle, then runs n_batches bipolar MAC
// evaluations and streams out the per-column ADC codes.
// Ports:
//   clk, nrst                       clock, asynchronous active-low reset
//   start_i, abort_i                job start pulse, synchronous abort
//   cfg_n_wrows_i/n_batches_i/settle_i  job configuration, latched on start
//   w_valid_i/w_ready_o/w_data_i    weight-row stream
//   x_valid_i/x_ready_o/x_p_i/x_n_i bipolar activation stream
//   res_valid_o/res_ready_i/res_data_o  ADC result stream
//   sram_rq_*                       SRAM write request channel
//   mac_en_o, data_p_o, data_n_o, adc_out_i  analog macro interface
//   busy_o, done_o                  status
module qracc_sequencer
    import qracc_pkg::*;
#(
    parameter int numRows    = 128,
    parameter int numCols    = 32,
    parameter int numAdcBits = 4
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           start_i,
    input  logic                           abort_i,
    input  logic [$clog2(numRows):0]       cfg_n_wrows_i,
    input  logic [15:0]                    cfg_n_batches_i,
    input  logic [3:0]                     cfg_settle_i,
    input  logic                           w_valid_i,
    output logic                           w_ready_o,
    input  logic [numCols-1:0]             w_data_i,
    input  logic                           x_valid_i,
    output logic                           x_ready_o,
    input  logic [numRows-1:0]             x_p_i,
    input  logic [numRows-1:0]             x_n_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [numCols*numAdcBits-1:0]  res_data_o,
    output logic                           sram_rq_valid_o,
    output logic                           sram_rq_wr_o,
    output logic [$clog2(numRows)-1:0]     sram_addr_o,
    output logic [numCols-1:0]             sram_wr_data_o,
    input  logic                           sram_rq_ready_i,
    output logic                           mac_en_o,
    output logic [numRows-1:0]             data_p_o,
    output logic [numRows-1:0]             data_n_o,
    input  logic [numCols*numAdcBits-1:0]  adc_out_i,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int ADDR_W = $clog2(numRows);
    localparam int ROW_W  = ADDR_W + 1;
    localparam int RES_W  = numCols * numAdcBits;

    seq_state_t          state_q, state_d;
    logic [ROW_W-1:0]    n_wrows_q;
    logic [15:0]         n_batches_q;
    logic [3:0]          settle_q;
    logic [ROW_W-1:0]    row_cnt_q;
    logic [15:0]         batch_cnt_q;
    logic [3:0]          settle_cnt_q;
    logic                rq_valid_q;
    logic [ADDR_W-1:0]   rq_addr_q;
    logic [numCols-1:0]  rq_data_q;
    logic [numRows-1:0]  x_p_q;
    logic [numRows-1:0]  x_n_q;
    logic [RES_W-1:0]    res_q;
    logic                abort_hold_q;

    logic w_fire, x_fire, res_fire, rq_fire, abort_req, rq_stuck;

    assign w_fire    = w_valid_i & w_ready_o;
    assign x_fire    = x_valid_i & x_ready_o;
    assign res_fire  = (state_q == MAC_OUT) & res_ready_i;
    assign rq_fire   = rq_valid_q & sram_rq_ready_i;
    // An abort seen while a write is outstanding is remembered until the
    // SRAM accepts that write, so the request is never withdrawn mid-flight.
    assign abort_req = abort_i | abort_hold_q;
    assign rq_stuck  = rq_valid_q & ~sram_rq_ready_i;

    // Next-state and handshake decode. New weight rows and activations are
    // refused while an abort is in progress.
    always_comb begin
        state_d   = state_q;
        w_ready_o = 1'b0;
        x_ready_o = 1'b0;
        mac_en_o  = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (cfg_n_wrows_i != '0) begin
                        state_d = WRITE;
                    end else begin
                        state_d = after_write_state(cfg_settle_i, cfg_n_batches_i);
                    end
                end
            end
            WRITE: begin
                w_ready_o = ~rq_valid_q & ~abort_req;
                if (rq_fire && (row_cnt_q + ROW_W'(1) == n_wrows_q)) begin
                    state_d = after_write_state(settle_q, n_batches_q);
                end
            end
            SETTLE: begin
                mac_en_o = 1'b1;
                if (settle_cnt_q == settle_q - 4'd1) begin
                    state_d = (n_batches_q != 16'd0) ? MAC_LOAD : DONE;
                end
            end
            MAC_LOAD: begin
                mac_en_o  = 1'b1;
                x_ready_o = ~abort_req;
                if (x_fire) begin
                    state_d = MAC_EVAL;
                end
            end
            MAC_EVAL: begin
                mac_en_o = 1'b1;
                state_d  = MAC_OUT;
            end
            MAC_OUT: begin
                mac_en_o = 1'b1;
                if (res_fire) begin
                    state_d = (batch_cnt_q + 16'd1 == n_batches_q) ? DONE : MAC_LOAD;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && abort_req && !rq_stuck) begin
            state_d = IDLE;
        end
    end

    // State, configuration, counters and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            n_wrows_q    <= '0;
            n_batches_q  <= '0;
            settle_q     <= '0;
            row_cnt_q    <= '0;
            batch_cnt_q  <= '0;
            settle_cnt_q <= '0;
            rq_valid_q   <= 1'b0;
            rq_addr_q    <= '0;
            rq_data_q    <= '0;
            x_p_q        <= '0;
            x_n_q        <= '0;
            res_q        <= '0;
            abort_hold_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_hold_q <= (state_q != IDLE) && (state_d != IDLE) && abort_req;
            if ((state_q == IDLE) && start_i) begin
                // Clamp so the row counter never addresses past the array.
                n_wrows_q    <= (cfg_n_wrows_i > ROW_W'(numRows)) ? ROW_W'(numRows)
                                                                  : cfg_n_wrows_i;
                n_batches_q  <= cfg_n_batches_i;
                settle_q     <= cfg_settle_i;
                row_cnt_q    <= '0;
                batch_cnt_q  <= '0;
                settle_cnt_q <= '0;
                x_p_q        <= '0;
                x_n_q        <= '0;
            end
            if (w_fire) begin
                rq_valid_q <= 1'b1;
                rq_addr_q  <= row_cnt_q[ADDR_W-1:0];
                rq_data_q  <= w_data_i;
            end else if (rq_fire) begin
                rq_valid_q <= 1'b0;
                row_cnt_q  <= row_cnt_q + ROW_W'(1);
            end
            if (state_q == SETTLE) begin
                settle_cnt_q <= settle_cnt_q + 4'd1;
            end
            if (x_fire) begin
                x_p_q <= x_p_i;
                x_n_q <= x_n_i;
            end
            if (state_q == MAC_EVAL) begin
                res_q <= adc_out_i;
            end
            if (res_fire) begin
                batch_cnt_q <= batch_cnt_q + 16'd1;
            end
        end
    end

    // Activations only reach the array while the analog path is enabled.
    assign data_p_o        = mac_en_o ? x_p_q : '0;
    assign data_n_o        = mac_en_o ? x_n_q : '0;
    assign res_valid_o     = (state_q == MAC_OUT);
    assign res_data_o      = res_q;
    assign sram_rq_valid_o = rq_valid_q;
    assign sram_rq_wr_o    = rq_valid_q;
    assign sram_addr_o     = rq_addr_q;
    assign sram_wr_data_o  = rq_data_q;
    assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_qracc_sequencer.sv
// tb_qracc_sequencer
// Bench for qracc_sequencer. A behavioural SRAM + CIM array model sits
// on the DUT's SRAM and analog ports; expected ADC codes come from the
// weight rows the bench intended to load and the activations it sent.
module tb_qracc_sequencer;

    localparam int NR    = 16;
    localparam int NC    = 8;
    localparam int AB    = 4;
    localparam int AW    = $clog2(NR);
    localparam int RW    = AW + 1;
    localparam int RES_W = NC * AB;

    typedef logic [NC-1:0] wmem_t [NR];

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              start_i = 1'b0, abort_i = 1'b0;
    logic [RW-1:0]     cfg_n_wrows_i = '0;
    logic [15:0]       cfg_n_batches_i = '0;
    logic [3:0]        cfg_settle_i = '0;
    logic              w_valid_i = 1'b0, w_ready_o;
    logic [NC-1:0]     w_data_i = '0;
    logic              x_valid_i = 1'b0, x_ready_o;
    logic [NR-1:0]     x_p_i = '0, x_n_i = '0;
    logic              res_valid_o, res_ready_i = 1'b0;
    logic [RES_W-1:0]  res_data_o;
    logic              sram_rq_valid_o, sram_rq_wr_o, sram_rq_ready_i = 1'b0;
    logic [AW-1:0]     sram_addr_o;
    logic [NC-1:0]     sram_wr_data_o;
    logic              mac_en_o;
    logic [NR-1:0]     data_p_o, data_n_o;
    logic [RES_W-1:0]  adc_out_i = '0;
    logic              busy_o, done_o;

    always #5 clk = ~clk;

    qracc_sequencer #(.numRows(NR), .numCols(NC), .numAdcBits(AB)) dut (
        .clk(clk), .nrst(nrst), .start_i(start_i), .abort_i(abort_i),
        .cfg_n_wrows_i(cfg_n_wrows_i), .cfg_n_batches_i(cfg_n_batches_i),
        .cfg_settle_i(cfg_settle_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_p_i(x_p_i), .x_n_i(x_n_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .sram_rq_valid_o(sram_rq_valid_o), .sram_rq_wr_o(sram_rq_wr_o),
        .sram_addr_o(sram_addr_o), .sram_wr_data_o(sram_wr_data_o),
        .sram_rq_ready_i(sram_rq_ready_i),
        .mac_en_o(mac_en_o), .data_p_o(data_p_o), .data_n_o(data_n_o),
        .adc_out_i(adc_out_i), .busy_o(busy_o), .done_o(done_o)
    );

    int errors = 0;
    int checks = 0;

    wmem_t sram_mem;
    wmem_t model_w;
    logic [NC-1:0]    w_rows[$];
    int               obs_addr[$];
    logic [NC-1:0]    obs_wdata[$];
    logic [RES_W-1:0] obs_res[$];
    logic [RES_W-1:0] exp_res[$];
    int               obs_lat[$];
    int done_cnt, settle_obs, rq_unstable, rq_notwr, res_unstable;
    int xr_bad, zero_bad, timed_out, stall_left;

    // Each column: offset 8 plus (+1 per active positive row, -1 per
    // active negative row) over rows whose weight bit is set, clipped to 0..15.
    function automatic logic [RES_W-1:0] adc_of(input wmem_t w, input logic [NR-1:0] p,
                                                input logic [NR-1:0] n);
        logic [RES_W-1:0] r;
        int acc;
        r = '0;
        for (int c = 0; c < NC; c++) begin
            acc = 8;
            for (int k = 0; k < NR; k++) begin
                if (w[k][c]) acc = acc + int'(p[k]) - int'(n[k]);
            end
            if (acc < 0) acc = 0;
            if (acc > 15) acc = 15;
            r[c*AB +: AB] = AB'(acc);
        end
        return r;
    endfunction

    // Runs one job with the environment responding cycle by cycle and
    // records what happened; the test tasks judge the records.
    task automatic run_job(input int n_wrows, input int settle, input int nb,
                           input int stall_batch, input int stall_cycles,
                           input int rq_delay, input int abort_cycle,
                           input bit start_abort, input bit exit_on_done);
        int cyc, w_idx, pend, x_cyc, idle_cnt;
        bit seen_xr, res_first;
        logic [AW-1:0]    addr_seen;
        logic [NC-1:0]    data_seen;
        logic [RES_W-1:0] res_seen;
        obs_addr.delete(); obs_wdata.delete(); obs_res.delete();
        exp_res.delete(); obs_lat.delete();
        done_cnt = 0; settle_obs = 0; rq_unstable = 0; rq_notwr = 0;
        res_unstable = 0; xr_bad = 0; zero_bad = 0; timed_out = 0;
        stall_left = stall_cycles;
        w_idx = 0; pend = 0; x_cyc = 0; idle_cnt = 0; seen_xr = 0; res_first = 1;
        addr_seen = '0; data_seen = '0; res_seen = '0;
        @(negedge clk);
        start_i = 1'b1; abort_i = start_abort;
        cfg_n_wrows_i = RW'(n_wrows); cfg_settle_i = 4'(settle); cfg_n_batches_i = 16'(nb);
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        cyc = 0;
        while (cyc < 400) begin
            w_valid_i       = (w_idx < w_rows.size()) && (w_idx < n_wrows);
            w_data_i        = w_valid_i ? w_rows[w_idx] : '0;
            x_valid_i       = 1'b1;
            x_p_i           = NR'($urandom);
            x_n_i           = NR'($urandom);
            sram_rq_ready_i = sram_rq_valid_o && (pend >= rq_delay);
            res_ready_i     = !(res_valid_o && obs_res.size() == stall_batch && stall_left > 0);
            abort_i         = (cyc == abort_cycle);
            adc_out_i       = adc_of(sram_mem, data_p_o, data_n_o);
            #1;
            if (sram_rq_valid_o) begin
                if (pend == 0) begin
                    addr_seen = sram_addr_o; data_seen = sram_wr_data_o;
                end else if (sram_addr_o !== addr_seen || sram_wr_data_o !== data_seen) begin
                    rq_unstable++;
                end
                if (sram_rq_wr_o !== 1'b1) rq_notwr++;
                if (mac_en_o) zero_bad++;
                if (sram_rq_ready_i) begin
                    obs_addr.push_back(int'(sram_addr_o));
                    obs_wdata.push_back(sram_wr_data_o);
                    sram_mem[sram_addr_o] = sram_wr_data_o;
                    pend = 0;
                end else begin
                    pend++;
                end
            end else begin
                pend = 0;
            end
            if (w_valid_i && w_ready_o) begin
                model_w[w_idx] = w_rows[w_idx];
                w_idx++;
            end
            if (mac_en_o && !x_ready_o && !seen_xr) settle_obs++;
            if (x_valid_i && x_ready_o) begin
                exp_res.push_back(adc_of(model_w, x_p_i, x_n_i));
                x_cyc = cyc; seen_xr = 1;
            end
            if (res_valid_o) begin
                if (res_first) begin
                    obs_lat.push_back(cyc - x_cyc);
                    res_seen = res_data_o; res_first = 0;
                end else if (res_data_o !== res_seen) begin
                    res_unstable++;
                end
                if (x_ready_o) xr_bad++;
                if (res_ready_i) begin
                    obs_res.push_back(res_data_o); res_first = 1;
                end else if (stall_left > 0) begin
                    stall_left--;
                end
            end
            if (!mac_en_o && (data_p_o !== '0 || data_n_o !== '0)) zero_bad++;
            if (done_o) done_cnt++;
            if (exit_on_done && done_o) break;
            if (!busy_o) idle_cnt++;
            if (idle_cnt >= 2) break;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 400) timed_out = 1;
        w_valid_i = 1'b0; x_valid_i = 1'b0; abort_i = 1'b0;
        sram_rq_ready_i = 1'b0; res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; start_i = 1'b1;
        cfg_n_wrows_i = '0; cfg_settle_i = '0; cfg_n_batches_i = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy_o, done_o, mac_en_o, res_valid_o, sram_rq_valid_o, w_ready_o, x_ready_o} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b want 0000000", {busy_o, done_o, mac_en_o,
                     res_valid_o, sram_rq_valid_o, w_ready_o, x_ready_o});
        end
        checks++;
        if ({res_data_o, data_p_o, data_n_o, sram_addr_o, sram_wr_data_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: res=%h p=%h n=%h (want all 0)", res_data_o, data_p_o, data_n_o);
        end
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL start_before_edge: busy=%b want 0", busy_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o} !== 2'b11) begin
            errors++; $display("[TB] FAIL empty_job_done: busy,done=%b want 11", {busy_o, done_o});
        end
        @(negedge clk);
        #1;
        checks++;
        if ({busy_o, done_o} !== 2'b00) begin
            errors++; $display("[TB] FAIL empty_job_idle: busy,done=%b want 00", {busy_o, done_o});
        end
    endtask

    task automatic test_write_rows();
        w_rows = '{8'h01, 8'h02, 8'h04, 8'h08};
        run_job(4, 0, 0, -1, 0, 3, -1, 1'b0, 1'b0);
        checks++;
        if (timed_out != 0 || obs_addr.size() != 4) begin
            errors++; $display("[TB] FAIL write_count: got %0d writes (timeout=%0d) want 4", obs_addr.size(), timed_out);
        end
        for (int i = 0; i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != i || obs_wdata[i] !== w_rows[i]) begin
                errors++;
                $display("[TB] FAIL write_%0d: addr=%0d data=%h want addr=%0d data=%h", i,
                         obs_addr[i], obs_wdata[i], i, w_rows[i]);
            end
        end
        checks++;
        if (rq_unstable != 0 || rq_notwr != 0 || zero_bad != 0) begin
            errors++; $display("[TB] FAIL write_stable: unstable=%0d notwr=%0d zero_bad=%0d want 0",
                               rq_unstable, rq_notwr, zero_bad);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("[TB] FAIL write_done: pulses=%0d want 1", done_cnt);
        end
    endtask

    task automatic test_settle_mac();
        w_rows.delete();
        run_job(0, 5, 2, -1, 0, 0, -1, 1'b0, 1'b0);
        checks++;
        if (settle_obs != 5) begin
            errors++; $display("[TB] FAIL settle_cycles: got %0d want 5", settle_obs);
        end
        checks++;
        if (obs_res.size() != 2 || timed_out != 0) begin
            errors++; $display("[TB] FAIL mac_count: got %0d results want 2", obs_res.size());
        end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i] || obs_lat[i] != 2) begin
                errors++; $display("[TB] FAIL mac_res_%0d: got %h lat %0d want %h lat 2", i,
                                   obs_res[i], obs_lat[i], exp_res[i]);
            end
        end
        checks++;
        if (done_cnt != 1 || zero_bad != 0) begin
            errors++; $display("[TB] FAIL mac_done: pulses=%0d zero_bad=%0d want 1/0", done_cnt, zero_bad);
        end
    endtask

    task automatic test_res_stall();
        run_job(0, 1, 3, 1, 4, 0, -1, 1'b0, 1'b0);
        checks++;
        if (obs_res.size() != 3 || done_cnt != 1) begin
            errors++; $display("[TB] FAIL stall_count: got %0d results %0d done want 3/1", obs_res.size(), done_cnt);
        end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i]) begin
                errors++; $display("[TB] FAIL stall_res_%0d: got %h want %h", i, obs_res[i], exp_res[i]);
            end
        end
        checks++;
        if (res_unstable != 0 || xr_bad != 0 || stall_left != 0) begin
            errors++; $display("[TB] FAIL stall_hold: unstable=%0d x_ready_bad=%0d stall_left=%0d want 0",
                               res_unstable, xr_bad, stall_left);
        end
    endtask

    task automatic test_abort_pending();
        w_rows = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_job(4, 0, 0, -1, 0, 3, 2, 1'b0, 1'b0);
        checks++;
        if (obs_addr.size() != 1 || timed_out != 0) begin
            errors++; $display("[TB] FAIL abort_writes: got %0d writes timeout=%0d want 1/0", obs_addr.size(), timed_out);
        end else begin
            checks++;
            if (obs_addr[0] != 0 || obs_wdata[0] !== 8'h11) begin
                errors++; $display("[TB] FAIL abort_write0: addr=%0d data=%h want 0/11", obs_addr[0], obs_wdata[0]);
            end
        end
        checks++;
        if (done_cnt != 0 || rq_unstable != 0 || busy_o !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_end: done=%0d unstable=%0d busy=%b want 0/0/0",
                               done_cnt, rq_unstable, busy_o);
        end
    endtask

    task automatic test_start_abort();
        run_job(0, 0, 1, -1, 0, 0, -1, 1'b1, 1'b0);
        checks++;
        if (settle_obs != 0 || done_cnt != 1 || obs_res.size() != 1) begin
            errors++; $display("[TB] FAIL start_abort: settle=%0d done=%0d results=%0d want 0/1/1",
                               settle_obs, done_cnt, obs_res.size());
        end else begin
            checks++;
            if (obs_res[0] !== exp_res[0]) begin
                errors++; $display("[TB] FAIL start_abort_res: got %h want %h", obs_res[0], exp_res[0]);
            end
        end
    endtask

    task automatic test_reset_mid_mac();
        bit fired;
        @(negedge clk);
        start_i = 1'b1; cfg_n_wrows_i = '0; cfg_settle_i = 4'd1; cfg_n_batches_i = 16'd1;
        @(negedge clk);
        start_i = 1'b0;
        fired = 0;
        for (int i = 0; i < 20 && !fired; i++) begin
            x_valid_i = 1'b1; x_p_i = NR'($urandom); x_n_i = NR'($urandom);
            adc_out_i = adc_of(sram_mem, data_p_o, data_n_o);
            #1;
            if (x_ready_o) fired = 1;
            @(negedge clk);
        end
        x_valid_i = 1'b0;
        #1;
        checks++;
        if (!fired || mac_en_o !== 1'b1 || res_valid_o !== 1'b0) begin
            errors++; $display("[TB] FAIL eval_reached: fired=%0d mac_en=%b res_valid=%b want 1/1/0",
                               fired, mac_en_o, res_valid_o);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, mac_en_o, res_valid_o, sram_rq_valid_o, x_ready_o, data_p_o, data_n_o,
             res_data_o} !== '0) begin
            errors++; $display("[TB] FAIL reset_mid_mac: busy=%b mac_en=%b p=%h res=%h want all 0",
                               busy_o, mac_en_o, data_p_o, res_data_o);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        w_rows.delete();
        for (int i = 0; i < 2; i++) w_rows.push_back(NC'($urandom));
        run_job(2, 2, 2, -1, 0, 1, -1, 1'b0, 1'b0);
        checks++;
        if (obs_addr.size() != 2 || obs_res.size() != 2 || done_cnt != 1) begin
            errors++; $display("[TB] FAIL post_reset_job: writes=%0d results=%0d done=%0d want 2/2/1",
                               obs_addr.size(), obs_res.size(), done_cnt);
        end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i]) begin
                errors++; $display("[TB] FAIL post_reset_res_%0d: got %h want %h", i, obs_res[i], exp_res[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        w_rows.delete();
        for (int i = 0; i < 2; i++) w_rows.push_back(NC'($urandom));
        run_job(2, 2, 1, -1, 0, 0, -1, 1'b0, 1'b1);
        checks++;
        if (done_cnt != 1 || obs_res.size() != 1 || obs_addr.size() != 2) begin
            errors++; $display("[TB] FAIL b2b_first: done=%0d results=%0d writes=%0d want 1/1/2",
                               done_cnt, obs_res.size(), obs_addr.size());
        end
        w_rows.delete();
        for (int i = 0; i < 3; i++) w_rows.push_back(NC'($urandom));
        run_job(3, 1, 2, -1, 0, 1, -1, 1'b0, 1'b0);
        checks++;
        if (obs_addr.size() != 3 || obs_res.size() != 2 || done_cnt != 1) begin
            errors++; $display("[TB] FAIL b2b_second: writes=%0d results=%0d done=%0d want 3/2/1",
                               obs_addr.size(), obs_res.size(), done_cnt);
        end
        for (int i = 0; i < obs_addr.size(); i++) begin
            checks++;
            if (obs_addr[i] != i || obs_wdata[i] !== w_rows[i]) begin
                errors++; $display("[TB] FAIL b2b_write_%0d: addr=%0d data=%h want %0d/%h", i,
                                   obs_addr[i], obs_wdata[i], i, w_rows[i]);
            end
        end
        for (int i = 0; i < obs_res.size() && i < exp_res.size(); i++) begin
            checks++;
            if (obs_res[i] !== exp_res[i]) begin
                errors++; $display("[TB] FAIL b2b_res_%0d: got %h want %h", i, obs_res[i], exp_res[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            sram_mem[i] = '0;
            model_w[i]  = '0;
        end
        test_reset();
        test_write_rows();
        test_settle_mac();
        test_res_stall();
        test_abort_pending();
        test_start_abort();
        test_reset_mid_mac();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
